// File: rtl/spi_cfg_arbiter.sv
// Two-requester register-write arbiter that serialises each write as a 6-byte
// SPI frame (sync, addr, data LSB first) and checks the slave's address echo.
module spi_cfg_arbiter #(
  parameter logic [7:0] SYNC_BYTE      = 8'h5A,
  parameter int         GAP_CYCLES     = 4,
  parameter int         TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rq0_valid,
  output logic        rq0_ready,
  input  logic [7:0]  rq0_addr,
  input  logic [31:0] rq0_data,
  input  logic        rq1_valid,
  output logic        rq1_ready,
  input  logic [7:0]  rq1_addr,
  input  logic [31:0] rq1_data,
  output logic        m_ready,
  output logic [7:0]  m_tx_data,
  input  logic        m_valid,
  input  logic [7:0]  m_rx_data,
  output logic        busy,
  output logic        done,
  output logic        done_id,
  output logic        echo_err,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

  localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        rdy0_q, rdy0_d, rdy1_q, rdy1_d;
  logic        owner_q, owner_d;
  logic [2:0]  idx_q, idx_d;
  logic        pause_q, pause_d;
  logic [19:0] tmr_q, tmr_d;
  logic [7:0]  gap_q, gap_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        done_id_q, done_id_d;
  logic        echo_err_q, echo_err_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  addr_q;
  logic [31:0] data_q;
  logic        take0, take1, load, echo_bad;
  logic [7:0]  tx_byte;

  // The ready pulse is registered, so the handshake lands one cycle after arbitration.
  assign take0    = rdy0_q && rq0_valid;
  assign take1    = rdy1_q && rq1_valid;
  assign load     = (state_q == IDLE) && (take0 || take1);
  assign echo_bad = (idx_q == 3'd2) && (m_rx_data != addr_q);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      rdy0_q     <= 1'b0;
      rdy1_q     <= 1'b0;
      owner_q    <= 1'b0;
      idx_q      <= 3'd0;
      pause_q    <= 1'b0;
      tmr_q      <= 20'd0;
      gap_q      <= 8'd0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      done_id_q  <= 1'b0;
      echo_err_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      rdy0_q     <= rdy0_d;
      rdy1_q     <= rdy1_d;
      owner_q    <= owner_d;
      idx_q      <= idx_d;
      pause_q    <= pause_d;
      tmr_q      <= tmr_d;
      gap_q      <= gap_d;
      err_q      <= err_d;
      done_q     <= done_d;
      done_id_q  <= done_id_d;
      echo_err_q <= echo_err_d;
      timeout_q  <= timeout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      addr_q <= take1 ? rq1_addr : rq0_addr;
      data_q <= take1 ? rq1_data : rq0_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    rdy0_d     = 1'b0;
    rdy1_d     = 1'b0;
    owner_d    = owner_q;
    idx_d      = idx_q;
    pause_d    = pause_q;
    tmr_d      = tmr_q;
    gap_d      = gap_q;
    err_d      = err_q;
    done_d     = 1'b0;
    done_id_d  = 1'b0;
    echo_err_d = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rdy0_q || rdy1_q) begin
          if (load) begin
            state_d = SEND;
            owner_d = take1;
            last_d  = take1;
            idx_d   = 3'd0;
            pause_d = 1'b0;
            tmr_d   = 20'd0;
            err_d   = 1'b0;
          end
        end else begin
          rdy0_d = rq0_valid && (!rq1_valid || last_q);
          rdy1_d = rq1_valid && (!rq0_valid || !last_q);
        end
      end
      SEND: begin
        if (pause_q) begin
          pause_d = 1'b0;
          idx_d   = idx_q + 3'd1;
          tmr_d   = 20'd0;
        end else if (m_valid) begin
          err_d = err_q || echo_bad;
          if (idx_q == 3'd5) begin
            done_d     = 1'b1;
            done_id_d  = owner_q;
            echo_err_d = err_q || echo_bad;
            state_d    = GAP;
            gap_d      = 8'd0;
          end else begin
            pause_d = 1'b1;
          end
        end else if (tmr_q == TMO_LAST) begin
          // Abort: the rest of the frame is dropped and the echo result is discarded.
          done_d    = 1'b1;
          done_id_d = owner_q;
          timeout_d = 1'b1;
          state_d   = GAP;
          gap_d     = 8'd0;
          tmr_d     = 20'd0;
        end else begin
          tmr_d = tmr_q + 20'd1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (idx_q)
      3'd1:    tx_byte = addr_q;
      3'd2:    tx_byte = data_q[7:0];
      3'd3:    tx_byte = data_q[15:8];
      3'd4:    tx_byte = data_q[23:16];
      3'd5:    tx_byte = data_q[31:24];
      default: tx_byte = SYNC_BYTE;
    endcase
  end

  always_comb begin
    m_ready   = (state_q == SEND) && !pause_q;
    m_tx_data = m_ready ? tx_byte : 8'h00;
    rq0_ready = rdy0_q;
    rq1_ready = rdy1_q;
    busy      = (state_q != IDLE);
    done      = done_q;
    done_id   = done_id_q;
    echo_err  = echo_err_q;
    timeout   = timeout_q;
  end

endmodule

// File: tb/tb_spi_cfg_arbiter.sv
// Scoreboard bench for spi_cfg_arbiter: a behavioural SPI master plus a
// negedge monitor that checks bytes, grants and done reports against queues.
module tb_spi_cfg_arbiter;
  localparam int GAP = 4;
  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rq0_valid, rq0_ready, rq1_valid, rq1_ready;
  logic [7:0]  rq0_addr, rq1_addr;
  logic [31:0] rq0_data, rq1_data;
  logic        m_ready, m_valid;
  logic [7:0]  m_tx_data, m_rx_data;
  logic        busy, done, done_id, echo_err, timeout;

  spi_cfg_arbiter #(.SYNC_BYTE(8'h5A), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_addr(rq0_addr), .rq0_data(rq0_data),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_addr(rq1_addr), .rq1_data(rq1_data),
    .m_ready(m_ready), .m_tx_data(m_tx_data), .m_valid(m_valid), .m_rx_data(m_rx_data),
    .busy(busy), .done(done), .done_id(done_id), .echo_err(echo_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_tx[$];
  logic       exp_grant[$];
  logic [2:0] exp_done[$];   // {id, echo_err, timeout}

  int total = 0;
  int bad   = 0;

  // master model controls
  int         delay = 10;
  int         stall_idx = 7;
  bit         echo_force_en = 0;
  logic [7:0] echo_force = 8'h00;
  bit         glitch_en = 0;
  int         mbcnt = 0;

  // monitor state
  int done_cnt = 0, run = 0, run_at_done = 0, since_done = 0, gap_busy = 0, mr_hi_cnt = 0;
  bit done_seen = 0, in_gap = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic expire(input string name);
    total++;
    bad++;
    $display("FAIL %s wait bound expired t=%0t", name, $time);
  endtask

  task automatic push_frame(input logic [7:0] a, input logic [31:0] d);
    exp_tx.push_back(8'h5A);
    exp_tx.push_back(a);
    exp_tx.push_back(d[7:0]);
    exp_tx.push_back(d[15:8]);
    exp_tx.push_back(d[23:16]);
    exp_tx.push_back(d[31:24]);
  endtask

  // SPI master: answers after `delay` offered cycles, optionally stalls or glitches
  initial begin
    int  wcnt = 0;
    bit  fired = 0;
    logic [7:0] cap = 8'h00;
    m_valid = 1'b0;
    m_rx_data = 8'h00;
    forever begin
      @(posedge clk); #1;
      m_valid = 1'b0;
      m_rx_data = 8'h00;
      if (rq0_ready || rq1_ready) begin
        mbcnt = 0;
        wcnt = 0;
      end
      if (m_ready) begin
        wcnt++;
        fired = 0;
        if (wcnt >= delay && mbcnt != stall_idx) begin
          if (mbcnt == 1) cap = m_tx_data;
          m_valid = 1'b1;
          m_rx_data = (mbcnt == 2) ? (echo_force_en ? echo_force : cap) : 8'(8'hC0 + mbcnt);
          mbcnt++;
          wcnt = 0;
          fired = 1;
        end
      end else begin
        wcnt = 0;
        if (glitch_en && fired) begin
          m_valid = 1'b1;
          m_rx_data = 8'hFF;
        end
        fired = 0;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        if (exp_tx.size() == 0) expire("tx_unexpected");
        else chk("tx_byte", {24'h0, m_tx_data}, {24'h0, exp_tx.pop_front()});
      end
      if (rq0_ready || rq1_ready) begin
        chk("ready_onehot", {31'h0, rq0_ready & rq1_ready}, 32'h0);
        if (exp_grant.size() == 0) expire("grant_unexpected");
        else chk("grant_id", {31'h0, rq1_ready}, {31'h0, exp_grant.pop_front()});
        if (done_seen) chk("gap_before_grant", {31'h0, since_done >= GAP}, 32'h1);
        done_seen = 0;
      end
      if (done) begin
        if (exp_done.size() == 0) expire("done_unexpected");
        else chk("done_fields", {29'h0, done_id, echo_err, timeout}, {29'h0, exp_done.pop_front()});
        done_cnt++;
        done_seen = 1;
        since_done = 0;
        in_gap = 1;
        gap_busy = 0;
      end else begin
        since_done++;
      end
      if (in_gap) begin
        if (busy) gap_busy++;
        else begin
          chk("gap_len", gap_busy, GAP);
          in_gap = 0;
        end
      end
      if (m_ready) begin
        run++;
        mr_hi_cnt++;
      end else begin
        if (done) run_at_done = run;
        run = 0;
      end
    end
  end

  task automatic check_reset_outputs();
    @(negedge clk);
    chk("rst_m_ready", {31'h0, m_ready}, 32'h0);
    chk("rst_m_tx_data", {24'h0, m_tx_data}, 32'h0);
    chk("rst_rq0_ready", {31'h0, rq0_ready}, 32'h0);
    chk("rst_rq1_ready", {31'h0, rq1_ready}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {28'h0, done, done_id, echo_err, timeout}, 32'h0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    done_seen = 0;
    in_gap = 0;
    check_reset_outputs();
  endtask

  task automatic wait_ready_drop(input bit which);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(which ? rq1_ready : rq0_ready) && n < 200);
    if (n >= 200) expire("wait_ready");
    @(posedge clk); #1;
    if (which) rq1_valid = 1'b0;
    else       rq0_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < target) expire("wait_done");
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 100);
    if (busy) expire("wait_idle");
  endtask

  task automatic single_write(input bit which, input logic [7:0] a, input logic [31:0] d,
                              input logic [2:0] dn);
    int d0 = done_cnt;
    exp_grant.push_back(which);
    push_frame(a, d);
    exp_done.push_back(dn);
    @(posedge clk); #1;
    if (which) begin rq1_addr = a; rq1_data = d; rq1_valid = 1'b1; end
    else       begin rq0_addr = a; rq0_data = d; rq0_valid = 1'b1; end
    wait_ready_drop(which);
    @(negedge clk);
    chk("busy_in_send", {31'h0, busy}, 32'h1);
    wait_done(d0 + 1);
    wait_idle();
  endtask

  initial begin
    int d0, c0, c1, mr0, n;
    rstn = 1'b0;
    rq0_valid = 1'b0; rq1_valid = 1'b0;
    rq0_addr = 8'h00; rq1_addr = 8'h00;
    rq0_data = 32'h0; rq1_data = 32'h0;
    @(posedge clk);
    @(posedge clk); #1;
    rstn = 1'b1;
    check_reset_outputs();

    // basic frame, good echo
    single_write(1'b0, 8'h03, 32'h11223344, 3'b000);
    chk("idle_after_frame", {31'h0, busy}, 32'h0);

    // bad echo: whole frame still sent, echo_err reported
    echo_force_en = 1; echo_force = 8'h07;
    single_write(1'b0, 8'h03, 32'h11223344, 3'b010);
    echo_force_en = 0;

    // last_grant was 0; reset must restore it so requester 0 wins the tie
    pulse_reset();
    d0 = done_cnt;
    exp_grant.push_back(1'b0); push_frame(8'h21, 32'hDEADBEEF); exp_done.push_back(3'b000);
    exp_grant.push_back(1'b1); push_frame(8'h42, 32'hCAFEF00D); exp_done.push_back(3'b100);
    exp_grant.push_back(1'b0); push_frame(8'h21, 32'hDEADBEEF); exp_done.push_back(3'b000);
    exp_grant.push_back(1'b1); push_frame(8'h42, 32'hCAFEF00D); exp_done.push_back(3'b100);
    @(posedge clk); #1;
    rq0_addr = 8'h21; rq0_data = 32'hDEADBEEF; rq0_valid = 1'b1;
    rq1_addr = 8'h42; rq1_data = 32'hCAFEF00D; rq1_valid = 1'b1;
    c0 = 0; c1 = 0; n = 0;
    while ((rq0_valid || rq1_valid) && n < 3000) begin
      @(negedge clk);
      if (rq0_ready) c0++;
      if (rq1_ready) c1++;
      @(posedge clk); #1;
      if (c0 == 2) rq0_valid = 1'b0;
      if (c1 == 2) rq1_valid = 1'b0;
      n++;
    end
    if (n >= 3000) expire("tie_grants");
    wait_done(d0 + 4);
    wait_idle();

    // m_valid pulses in the low cycle between bytes must be ignored
    glitch_en = 1;
    single_write(1'b1, 8'h55, 32'h01020304, 3'b100);
    glitch_en = 0;

    // timeout at index 1: byte 0 completes, abort after 20 offered cycles
    stall_idx = 1;
    d0 = done_cnt;
    exp_grant.push_back(1'b0);
    exp_tx.push_back(8'h5A);
    exp_done.push_back(3'b001);
    @(posedge clk); #1;
    rq0_addr = 8'h77; rq0_data = 32'h99887766; rq0_valid = 1'b1;
    wait_ready_drop(1'b0);
    wait_done(d0 + 1);
    chk("abort_latency", run_at_done, TMO);
    mr0 = mr_hi_cnt;
    repeat (GAP + 4) @(negedge clk);
    chk("no_bytes_after_abort", mr_hi_cnt - mr0, 0);
    chk("idle_after_abort", {31'h0, busy}, 32'h0);
    stall_idx = 7;

    // reset during index 3 with rq1 held: no done, then a fresh frame from 5A
    d0 = done_cnt;
    exp_grant.push_back(1'b1);
    exp_tx.push_back(8'h5A); exp_tx.push_back(8'h10); exp_tx.push_back(8'hD4);
    @(posedge clk); #1;
    rq1_addr = 8'h10; rq1_data = 32'hA1B2C3D4; rq1_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mbcnt == 3 && m_ready) && n < 500);
    if (n >= 500) expire("reach_index3");
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    done_seen = 0;
    in_gap = 0;
    exp_grant.push_back(1'b1);
    push_frame(8'h10, 32'hA1B2C3D4);
    exp_done.push_back(3'b100);
    check_reset_outputs();
    chk("no_done_on_reset", done_cnt, d0);
    wait_ready_drop(1'b1);
    wait_done(d0 + 1);
    wait_idle();

    chk("tx_queue_empty", exp_tx.size(), 0);
    chk("grant_queue_empty", exp_grant.size(), 0);
    chk("done_queue_empty", exp_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit reached");
  end
endmodule
